// File: rtl/muldiv_seq_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  // ALU opcodes understood by the shared execute-stage ALU
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd8;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_ITER = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  // Operation captured at launch
  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } md_op_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? XLEN'(XLEN'(0) - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Final result selection: sign restore on product/quotient/remainder and RISC-V divide corner cases.
module muldiv_fixup
  import muldiv_seq_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic            neg_res,
  output logic [XLEN-1:0] result_c
);

  logic [2*XLEN-1:0] prod_s;
  logic              div_zero;
  logic              div_ovf;

  assign prod_s   = neg_res ? (2*XLEN)'((2*XLEN)'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
  assign div_zero = funct3[2] && (op_b == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

  always_comb begin
    result_c = '0;
    case (funct3)
      F3_MUL:                          result_c = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:    result_c = prod_s[2*XLEN-1:XLEN];
      F3_DIV:                          result_c = neg_if(acc_lo, neg_res);
      F3_DIVU:                         result_c = acc_lo;
      F3_REM:                          result_c = neg_if(acc_hi, neg_res);
      default:                         result_c = acc_hi;
    endcase
    // Architectural results take priority over whatever the datapath produced
    if (div_zero) begin
      result_c = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      result_c = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer borrowing the shared execute-stage ALU.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WORD_SIZE = XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 kill,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] rs1,
  input  logic [WORD_SIZE-1:0] rs2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic [3:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_arg1,
  output logic [WORD_SIZE-1:0] alu_arg2,
  input  logic [WORD_SIZE-1:0] alu_result
);

  md_state_e       state_q, state_d;
  md_op_t          op_q, op_d;
  logic [XLEN-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_res_q, neg_res_d;
  logic [XLEN-1:0] result_d;
  logic            busy_d, done_d;
  logic [3:0]      alu_op_d;
  logic [XLEN-1:0] alu_arg1_d, alu_arg2_d;

  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sum;
  logic            carry, q_bit;
  logic [XLEN-1:0] fix_result_c;

  assign is_div   = op_q.funct3[2];
  assign a_signed = (op_q.funct3 == F3_MULH) || (op_q.funct3 == F3_MULHSU) ||
                    (op_q.funct3 == F3_DIV)  || (op_q.funct3 == F3_REM);
  assign b_signed = (op_q.funct3 == F3_MULH) || (op_q.funct3 == F3_DIV) ||
                    (op_q.funct3 == F3_REM);
  assign a_neg    = a_signed && op_q.a[XLEN-1];
  assign b_neg    = b_signed && op_q.b[XLEN-1];

  muldiv_fixup u_fixup (
    .funct3   (op_q.funct3),
    .op_a     (op_q.a),
    .op_b     (op_q.b),
    .acc_hi   (acc_hi_q),
    .acc_lo   (acc_lo_q),
    .neg_res  (neg_res_q),
    .result_c (fix_result_c)
  );

  // Next-state, datapath and next-cycle output values
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    result_d   = result;
    shifted    = '0;
    sum        = '0;
    carry      = 1'b0;
    q_bit      = 1'b0;
    alu_op_d   = ALU_ADD;
    alu_arg1_d = '0;
    alu_arg2_d = '0;

    case (state_q)
      MD_IDLE: begin
        if (start && !kill) begin
          op_d    = '{funct3: funct3, a: rs1, b: rs2};
          state_d = MD_PREP;
        end
      end
      MD_PREP: begin
        mag_a_d   = neg_if(op_q.a, a_neg);
        mag_b_d   = neg_if(op_q.b, b_neg);
        neg_res_d = (op_q.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
        cnt_d     = CNT_W'(XLEN - 1);
        acc_hi_d  = '0;
        acc_lo_d  = is_div ? mag_a_d : mag_b_d;
        state_d   = MD_ITER;
      end
      MD_ITER: begin
        if (!is_div) begin
          // Shift-add: the ALU supplies acc_hi + |A|, carry recovered from wraparound
          if (acc_lo_q[0]) begin
            sum   = alu_result;
            carry = (alu_result < acc_hi_q);
          end else begin
            sum   = acc_hi_q;
          end
          acc_hi_d = {carry, sum[XLEN-1:1]};
          acc_lo_d = {sum[0], acc_lo_q[XLEN-1:1]};
        end else begin
          // Restoring division: the ALU supplies shifted - |B|
          shifted  = {acc_hi_q, acc_lo_q[XLEN-1]};
          q_bit    = (shifted >= {1'b0, mag_b_q});
          acc_hi_d = q_bit ? alu_result : shifted[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], q_bit};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        result_d = fix_result_c;
        state_d  = MD_DONE;
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase

    if (kill && (state_q != MD_IDLE)) begin
      state_d  = MD_IDLE;
      result_d = result;
    end

    busy_d = (state_d != MD_IDLE);
    done_d = (state_d == MD_DONE);

    // ALU operands are prepared one cycle ahead so they are registered when ITER uses them
    if (state_d == MD_ITER) begin
      if (op_q.funct3[2]) begin
        alu_op_d   = ALU_SUB;
        alu_arg1_d = {acc_hi_d[XLEN-2:0], acc_lo_d[XLEN-1]};
        alu_arg2_d = mag_b_d;
      end else begin
        alu_op_d   = ALU_ADD;
        alu_arg1_d = acc_hi_d;
        alu_arg2_d = mag_a_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_op    <= ALU_ADD;
      alu_arg1  <= '0;
      alu_arg2  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      result    <= result_d;
      busy      <= busy_d;
      done      <= done_d;
      alu_op    <= alu_op_d;
      alu_arg1  <= alu_arg1_d;
      alu_arg2  <= alu_arg2_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level reference model plus directed RV32M vectors.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk, rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic [31:0] alu_arg1, alu_arg2, alu_result;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  muldiv_seq #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_result(alu_result)
  );

  // Shared ALU stand-in
  assign alu_result = (alu_op == ALU_SUB) ? alu_arg1 - alu_arg2 : alu_arg1 + alu_arg2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? 32'(0 - x) : x;
  endfunction

  // Reference model: t counts edges since the accepting edge; done at t==34
  bit          m_seen_rst = 0;
  bit          m_active = 0;
  int          m_t = 0;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_a = '0, m_b = '0, m_result = '0, m_arg2 = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_seen_rst <= 1;
      m_active   <= 0;
      m_t        <= 0;
      m_result   <= '0;
    end else if (m_active) begin
      if (kill || m_t == 34) m_active <= 0;
      else begin
        if (m_t == 33) m_result <= ref_result(m_f3, m_a, m_b);
        m_t <= m_t + 1;
      end
    end else if (start && !kill) begin
      m_active <= 1;
      m_t      <= 0;
      m_f3     <= funct3;
      m_a      <= rs1;
      m_b      <= rs2;
      m_arg2   <= funct3[2] ? mag(rs2, funct3 == 3'd4 || funct3 == 3'd6 || funct3 == 3'd1)
                            : mag(rs1, funct3 == 3'd1 || funct3 == 3'd2);
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_seen_rst) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_active && m_t == 34));
      check("result", result, m_result);
      if (m_active && m_t >= 1 && m_t <= 32) begin
        check("alu_op iter", 32'(alu_op), 32'(m_f3[2] ? ALU_SUB : ALU_ADD));
        check("alu_arg2 iter", alu_arg2, m_arg2);
        if (m_t == 1 && !m_f3[2]) check("alu_arg1 first mul iter", alu_arg1, 32'h0);
      end else begin
        check("alu_op idle", 32'(alu_op), 32'(ALU_ADD));
        check("alu_arg1 idle", alu_arg1, 32'h0);
        check("alu_arg2 idle", alu_arg2, 32'h0);
      end
    end
  end

  // Launch one op from IDLE, expect done 35 cycles later with a literal result
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    bit got;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; got = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1; lat = i; end
    end
    check({name, " latency"}, 32'(lat), 32'd35);
    check(name, result, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", result, 32'h0);
    check("reset alu_op", 32'(alu_op), 32'(ALU_ADD));
    @(posedge clk); #1;

    run_op(F3_MUL,    32'd7,          32'd6,          32'd42,         "MUL 7*6");
    run_op(F3_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  "MUL -3*5");
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "MULHU max");
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  "MULH -1*-1");
    run_op(F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  "MULH min*min");
    run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  "MULHSU -1*2");
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "DIV -7/2");
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "REM -7%2");
    run_op(F3_DIVU,   32'd100,        32'd7,          32'd14,         "DIVU 100/7");
    run_op(F3_REMU,   32'd100,        32'd7,          32'd2,          "REMU 100%7");
    run_op(F3_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  "DIVU by zero");
    run_op(F3_REM,    32'd5,          32'd0,          32'd5,          "REM by zero");
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "DIV overflow");
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          "REM overflow");

    // Kill during ITER cycle 10, then an immediate new launch
    c0 = done_cnt;
    funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    check("busy after kill", 32'(busy), 32'd0);
    check("no done after kill", 32'(done_cnt - c0), 32'd0);
    run_op(F3_MUL, 32'd3, 32'd5, 32'd15, "MUL after kill");

    // start together with kill in IDLE is ignored
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    check("start+kill ignored", 32'(busy), 32'd0);

    // Reset in the middle of ITER
    funct3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset result", result, 32'h0);
    check("mid reset alu_arg1", alu_arg1, 32'h0);
    run_op(F3_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "DIV 100/-7");

    // start held high for the whole operation yields a single done
    c0 = done_cnt;
    funct3 = F3_REMU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    repeat (36) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("held start done count", 32'(done_cnt - c0), 32'd1);
    check("held start result", result, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer in the execute stage. It borrows the shared 32-bit combinational ALU and drives alu_op/arg1/arg2 for one add or sub per cycle.
- It runs shift-add multiply and restoring division, then applies sign fix-up and RISC-V corner-case results.
- The pipeline stalls on busy and captures result on the done pulse.

Parameters:
- WORD_SIZE, 32, operand/result width. Only 32 is supported; the iteration count equals WORD_SIZE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch operation; sampled only in IDLE
- kill  in  1  pipeline flush; aborts the operation with no done
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  WORD_SIZE  operand A (multiplicand/dividend)
- rs2  in  WORD_SIZE  operand B (multiplier/divisor)
- busy  out  1  high from the cycle after start until done, inclusive
- done  out  1  one-cycle pulse; result valid only this cycle
- result  out  WORD_SIZE  final value
- alu_op  out  4  ALU opcode (ALU_ADD / ALU_SUB)
- alu_arg1  out  WORD_SIZE  ALU operand 1
- alu_arg2  out  WORD_SIZE  ALU operand 2
- alu_result  in  WORD_SIZE  combinational ALU output, same cycle

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, result=0.
  - alu_op=ALU_ADD, alu_arg1=alu_arg2=0.
  - All internal registers cleared. Reset wins over start and kill in the same cycle.
- FSM IDLE -> PREP -> ITER(x32) -> FIX -> DONE -> IDLE.
- Fixed latency: start accepted at edge N gives done high in cycle N+35, for every funct3 including corner cases.
- IDLE:
  - start=1 latches funct3, rs1, rs2 and goes to PREP. start=0 stays.
  - ALU outputs are idle (ADD, 0, 0).
- PREP:
  - Form magnitudes locally, no ALU use.
  - A is signed for MULH, MULHSU, DIV, REM. B is signed for MULH, DIV, REM.
  - Record neg_res: for MUL*, sign(A) xor sign(B); for DIV, sign(A) xor sign(B); for REM, sign(A).
  - Load iteration counter = 31. Clear acc_hi. acc_lo = |B| for multiply, |A| for divide.
- ITER, multiply, one cycle each:
  - alu_op=ADD, arg1=acc_hi, arg2=|A|.
  - If acc_lo[0]=1, sum=alu_result and carry=(alu_result < acc_hi) unsigned, computed locally. Otherwise sum=acc_hi and carry=0.
  - {acc_hi,acc_lo} <= {carry,sum,acc_lo[31:1]}.
- ITER, divide, one cycle each:
  - shifted = {acc_hi[31:0],acc_lo[31]}, 33 bits.
  - alu_op=SUB, arg1=shifted[31:0], arg2=|B|.
  - If shifted >= |B| (local 33-bit compare): acc_hi <= alu_result and quotient bit=1. Otherwise acc_hi <= shifted[31:0] and bit=0.
  - acc_lo <= {acc_lo[30:0],bit}.
- Counter decrements each ITER cycle; at 0 go to FIX.
- FIX:
  - Select the 64-bit product (negated locally if neg_res): MUL takes low 32 bits, the others take high 32 bits.
  - DIV/DIVU takes acc_lo as quotient; REM/REMU takes acc_hi as remainder. Negate if neg_res and signed op.
  - Overrides: divisor==0 gives quotient 0xFFFFFFFF and remainder = original rs1. DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
  - Register result.
- DONE: done=1 for one cycle, busy=1, then IDLE. result holds its value until the next FIX or reset.
- kill:
  - In any state except IDLE, go to IDLE next cycle. busy drops next cycle and done is not asserted.
  - kill together with start in IDLE: start is ignored.
- start while busy is ignored; the operation is not queued.
- ALU outputs are only meaningful in ITER. Outside ITER they are held at the idle values, so an external mux may select this block on busy.

Decomposition:
- defines.vh, shared:
  - ALU opcode constants ALU_ADD, ALU_SUB (4-bit), reused by the ALU.
  - funct3 constants F3_MUL..F3_REMU.
  - State encodings MD_IDLE, MD_PREP, MD_ITER, MD_FIX, MD_DONE.
- Sub-module muldiv_fixup: combinational corner-case override and sign negation used in FIX, unit-testable in isolation.

Test Plan:
- MUL rs1=7, rs2=6, start pulse -> busy 1 for 35 cycles, done pulse at N+35, result=42; alu_op=ADD throughout ITER.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> result=0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> result=0xFFFFFFFF.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU rs1=100, rs2=7 -> 14. REMU rs1=100, rs2=7 -> 2.
- Corner cases: DIVU rs1=5, rs2=0 -> 0xFFFFFFFF. REM rs1=5, rs2=0 -> 5. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. All complete in 35 cycles.
- kill asserted during ITER cycle 10 -> busy low next cycle, done never pulses. A new start the cycle after that is accepted and completes correctly.
- rst asserted mid-ITER -> next cycle all outputs at reset values. start held high during busy -> exactly one done per accepted start.
